// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-high segment patterns (bit0=a .. bit6=g),
// the nibble type and the capture FSM state encoding.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef logic [3:0]       nibble_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment table: active-high pattern -> nibble.
// A blank pattern is reported separately so the caller can skip it without flagging an error.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_t    pattern,
    output nibble_t nibble,
    output logic    legal,
    output logic    blank
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        blank  = 1'b0;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_hex_capture.sv
// Samples a multiplexed active-low 7-segment bus, debounces each digit, decodes it and
// presents the assembled word with a valid/ready handshake.
module seg7_hex_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SEG_W-1:0]        seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic [4*NUM_DIGITS-1:0] word_data,
    output logic                    word_err,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    err_pulse
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);

    seg_t                    seg_reg;
    seg_t                    seg_prev_reg;
    logic [NUM_DIGITS-1:0]   sel_reg;
    logic [NUM_DIGITS-1:0]   sel_prev_reg;
    logic [CNT_W-1:0]        cnt_reg;
    cap_state_t              state_reg;
    logic [NUM_DIGITS-1:0]   mask_reg;
    logic                    frame_err_reg;
    nibble_t                 slot_reg [NUM_DIGITS];

    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic                    sel_legal;
    logic                    inputs_changed;
    logic                    capture;
    nibble_t                 dec_nibble;
    logic                    dec_legal;
    logic                    dec_blank;
    logic                    cap_store;
    logic                    cap_illegal;
    logic [NUM_DIGITS-1:0]   slot_we;
    logic [4*NUM_DIGITS-1:0] slot_word;

    seg7_pattern_decode u_decode (
        .pattern (~seg_reg),
        .nibble  (dec_nibble),
        .legal   (dec_legal),
        .blank   (dec_blank)
    );

    assign sel_onehot     = ~sel_reg;
    assign sel_legal      = $onehot(sel_onehot);
    assign inputs_changed = (seg_reg != seg_prev_reg) || (sel_reg != sel_prev_reg);
    // Fires only on the step into STABLE_CYCLES-1, so a held digit is captured once.
    assign capture        = sel_legal && !inputs_changed && (cnt_reg == CNT_FIRE);
    assign cap_store      = capture && !dec_blank;
    assign cap_illegal    = capture && !dec_blank && !dec_legal;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        assign slot_we[gi]            = cap_store && sel_onehot[gi] && (state_reg == ST_COLLECT);
        assign slot_word[4*gi +: 4]   = slot_reg[gi];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_reg       <= '1;
            seg_prev_reg  <= '1;
            sel_reg       <= '1;
            sel_prev_reg  <= '1;
            cnt_reg       <= '0;
            state_reg     <= ST_COLLECT;
            mask_reg      <= '0;
            frame_err_reg <= 1'b0;
            word_data     <= '0;
            word_err      <= 1'b0;
            word_valid    <= 1'b0;
            err_pulse     <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            seg_reg      <= seg_n;
            seg_prev_reg <= seg_reg;
            sel_reg      <= dig_sel_n;
            sel_prev_reg <= sel_reg;

            if (!sel_legal || inputs_changed) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            err_pulse <= cap_illegal;

            case (state_reg)
                ST_COLLECT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (slot_we[i]) begin
                            slot_reg[i] <= dec_legal ? dec_nibble : 4'h0;
                            mask_reg[i] <= 1'b1;
                        end
                    end
                    if (cap_illegal) begin
                        frame_err_reg <= 1'b1;
                    end
                    if (&mask_reg) begin
                        state_reg  <= ST_HOLD;
                        word_valid <= 1'b1;
                        word_data  <= slot_word;
                        word_err   <= frame_err_reg;
                    end
                end
                ST_HOLD: begin
                    // Captures seen here are dropped; only the handshake moves us on.
                    if (word_ready) begin
                        word_valid    <= 1'b0;
                        mask_reg      <= '0;
                        frame_err_reg <= 1'b0;
                        state_reg     <= ST_COLLECT;
                    end
                end
                default: state_reg <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_hex_capture.sv
// Directed bench for seg7_hex_capture: each task drives one scenario and checks inline.
module tb_seg7_hex_capture;

    logic        clk;
    logic        reset_n;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel_n;
    logic [15:0] word_data;
    logic        word_err;
    logic        word_valid;
    logic        word_ready;
    logic        err_pulse;

    int          total = 0;
    int          bad   = 0;
    int          hs_cnt   = 0;
    int          errp_cnt = 0;
    int          valid_hi = 0;
    logic [15:0] last_data = '0;
    logic        last_err  = 1'b0;

    seg7_hex_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_n      (seg_n),
        .dig_sel_n  (dig_sel_n),
        .word_data  (word_data),
        .word_err   (word_err),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err_pulse  (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid && word_ready) begin
            hs_cnt    <= hs_cnt + 1;
            last_data <= word_data;
            last_err  <= word_err;
            $display("accept word_data=%h word_err=%0b t=%0t", word_data, word_err, $time);
        end
        if (err_pulse)  errp_cnt <= errp_cnt + 1;
        if (word_valid) valid_hi <= valid_hi + 1;
    end

    task automatic show_digit(input int idx, input logic [6:0] p, input int n);
        logic [3:0] sel;
        sel       = 4'b1111;
        sel[idx]  = 1'b0;
        dig_sel_n = sel;
        seg_n     = ~p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dig_sel_n = 4'b1111;
        seg_n     = 7'h7F;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        word_ready = 1'b0;
        dig_sel_n  = 4'b1111;
        seg_n      = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        total++; if (word_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", word_data); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
        total++; if (word_err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", word_err); end
        total++; if (err_pulse !== 1'b0)  begin bad++; $display("FAIL reset_errp got=%b exp=0", err_pulse); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int h0, v0;
        word_ready = 1'b1;
        h0 = hs_cnt;
        v0 = valid_hi;
        show_digit(0, 7'h3F, 20);
        show_digit(1, 7'h06, 20);
        show_digit(2, 7'h5B, 20);
        show_digit(3, 7'h4F, 20);
        total++; if (hs_cnt !== h0 + 1)     begin bad++; $display("FAIL basic_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
        total++; if (last_data !== 16'h3210) begin bad++; $display("FAIL basic_data got=%h exp=3210", last_data); end
        total++; if (last_err !== 1'b0)      begin bad++; $display("FAIL basic_err got=%b exp=0", last_err); end
        total++; if (valid_hi !== v0 + 1)   begin bad++; $display("FAIL basic_valid_len got=%0d exp=1", valid_hi - v0); end
        idle(5);
    endtask

    task automatic test_short_hold;
        int h0;
        word_ready = 1'b1;
        h0 = hs_cnt;
        show_digit(0, 7'h7F, 14);
        show_digit(1, 7'h07, 20);
        show_digit(2, 7'h7D, 20);
        show_digit(3, 7'h6D, 20);
        total++; if (hs_cnt !== h0) begin bad++; $display("FAIL short_no_word got=%0d exp=%0d", hs_cnt, h0); end
        show_digit(0, 7'h66, 20);
        total++; if (hs_cnt !== h0 + 1)     begin bad++; $display("FAIL short_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
        total++; if (last_data !== 16'h5674) begin bad++; $display("FAIL short_data got=%h exp=5674", last_data); end
        idle(5);
    endtask

    task automatic test_illegal_pattern;
        int h0, e0;
        word_ready = 1'b1;
        h0 = hs_cnt;
        e0 = errp_cnt;
        show_digit(0, 7'h06, 20);
        show_digit(1, 7'h5B, 20);
        show_digit(2, 7'h55, 20);
        show_digit(3, 7'h4F, 20);
        total++; if (errp_cnt !== e0 + 1)    begin bad++; $display("FAIL illegal_errp got=%0d exp=%0d", errp_cnt, e0 + 1); end
        total++; if (hs_cnt !== h0 + 1)      begin bad++; $display("FAIL illegal_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
        total++; if (last_data !== 16'h3021) begin bad++; $display("FAIL illegal_data got=%h exp=3021", last_data); end
        total++; if (last_err !== 1'b1)      begin bad++; $display("FAIL illegal_err got=%b exp=1", last_err); end
        idle(5);
    endtask

    task automatic test_backpressure;
        int h0, v0;
        word_ready = 1'b0;
        h0 = hs_cnt;
        show_digit(0, 7'h39, 20);
        show_digit(1, 7'h5E, 20);
        show_digit(2, 7'h79, 20);
        show_digit(3, 7'h71, 20);
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", word_valid); end
        v0 = valid_hi;
        show_digit(0, 7'h77, 20);
        show_digit(1, 7'h7C, 20);
        show_digit(2, 7'h6F, 20);
        show_digit(3, 7'h07, 20);
        total++; if (valid_hi !== v0 + 80)   begin bad++; $display("FAIL bp_valid_held got=%0d exp=80", valid_hi - v0); end
        total++; if (word_data !== 16'hFEDC) begin bad++; $display("FAIL bp_data_stable got=%h exp=fedc", word_data); end
        total++; if (hs_cnt !== h0)          begin bad++; $display("FAIL bp_no_hs got=%0d exp=%0d", hs_cnt, h0); end
        dig_sel_n  = 4'b1111;
        seg_n      = 7'h7F;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (hs_cnt !== h0 + 1)      begin bad++; $display("FAIL bp_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
        total++; if (last_data !== 16'hFEDC) begin bad++; $display("FAIL bp_acc_data got=%h exp=fedc", last_data); end
        total++; if (word_valid !== 1'b0)    begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", word_valid); end
        idle(5);
        show_digit(0, 7'h06, 20);
        show_digit(1, 7'h06, 20);
        show_digit(2, 7'h06, 20);
        total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL bp_fresh_partial got=%0d exp=%0d", hs_cnt, h0 + 1); end
        show_digit(3, 7'h06, 20);
        total++; if (hs_cnt !== h0 + 2)      begin bad++; $display("FAIL bp_fresh_hs got=%0d exp=%0d", hs_cnt, h0 + 2); end
        total++; if (last_data !== 16'h1111) begin bad++; $display("FAIL bp_fresh_data got=%h exp=1111", last_data); end
        idle(5);
    endtask

    task automatic test_illegal_select;
        int h0, e0;
        word_ready = 1'b1;
        h0 = hs_cnt;
        e0 = errp_cnt;
        dig_sel_n = 4'b0011;
        seg_n     = ~7'h3F;
        repeat (40) @(posedge clk);
        #1;
        dig_sel_n = 4'b1111;
        seg_n     = 7'h7F;
        repeat (40) @(posedge clk);
        #1;
        dig_sel_n = 4'b1110;
        seg_n     = 7'h7F;
        repeat (40) @(posedge clk);
        #1;
        total++; if (errp_cnt !== e0)     begin bad++; $display("FAIL sel_errp got=%0d exp=%0d", errp_cnt, e0); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL sel_valid got=%b exp=0", word_valid); end
        show_digit(1, 7'h5B, 20);
        show_digit(2, 7'h4F, 20);
        show_digit(3, 7'h66, 20);
        total++; if (hs_cnt !== h0) begin bad++; $display("FAIL sel_no_capture got=%0d exp=%0d", hs_cnt, h0); end
        show_digit(0, 7'h3F, 20);
        total++; if (hs_cnt !== h0 + 1)      begin bad++; $display("FAIL sel_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
        total++; if (last_data !== 16'h4320) begin bad++; $display("FAIL sel_data got=%h exp=4320", last_data); end
        idle(5);
    endtask

    task automatic test_reset_midframe;
        int h0;
        word_ready = 1'b1;
        show_digit(0, 7'h3F, 20);
        show_digit(1, 7'h06, 20);
        show_digit(2, 7'h5B, 20);
        idle(2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (word_data !== 16'h0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0000", word_data); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", word_valid); end
        total++; if (word_err !== 1'b0)   begin bad++; $display("FAIL mid_rst_err got=%b exp=0", word_err); end
        reset_n = 1'b1;
        h0 = hs_cnt;
        show_digit(3, 7'h4F, 20);
        total++; if (hs_cnt !== h0) begin bad++; $display("FAIL mid_partial got=%0d exp=%0d", hs_cnt, h0); end
        show_digit(0, 7'h66, 20);
        show_digit(1, 7'h6D, 20);
        show_digit(2, 7'h7D, 20);
        total++; if (hs_cnt !== h0 + 1)      begin bad++; $display("FAIL mid_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
        total++; if (last_data !== 16'h3654) begin bad++; $display("FAIL mid_data got=%h exp=3654", last_data); end
        idle(5);
    endtask

    initial begin
        reset_n    = 1'b0;
        word_ready = 1'b0;
        dig_sel_n  = 4'b1111;
        seg_n      = 7'h7F;
        test_reset();
        test_basic();
        test_short_hold();
        test_illegal_pattern();
        test_backpressure();
        test_illegal_select();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
